// File: rtl/latch_write_scheduler_pkg.sv
// Shared definitions for the latch write scheduler: FSM state encoding and
// default parameter values.
package latch_write_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_N_REQ       = 4;
  localparam int DEF_OPEN_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES = 1;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin picker: selects the first set req bit at or
// after ptr, wrapping 3 -> 0.
module rr_arbiter_4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] sel,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = ptr;
    any = 1'b0;
    // Scan from farthest to nearest so the candidate closest to ptr wins.
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        idx = ptr + 2'(k);
        any = 1'b1;
      end
    end
    sel = any ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/latch_write_scheduler.sv
// Sequences writes from N_REQ requesters into one shared level-sensitive latch
// bank as SETUP / OPEN / HOLD so the enable never opens while d moves.
module latch_write_scheduler
  import latch_write_scheduler_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_REQ       = DEF_N_REQ,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       latch_d,
  output logic                   latch_en
);

  localparam int CNT_MAX = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0]         ptr, ptr_n;
  logic [N_REQ-1:0]   gnt_n, done_n;
  logic [WIDTH-1:0]   latch_d_n;
  logic               latch_en_n;

  logic [3:0]         arb_sel;
  logic [1:0]         arb_idx;
  logic               arb_any;

  rr_arbiter_4 u_arb (
    .req (req),
    .ptr (ptr),
    .sel (arb_sel),
    .idx (arb_idx),
    .any (arb_any)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gnt      <= '0;
      done     <= '0;
      latch_d  <= '0;
      latch_en <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      done     <= done_n;
      latch_d  <= latch_d_n;
      latch_en <= latch_en_n;
    end
  end

  // NOTE: each combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (arb_any) state_n = SETUP;
      SETUP: state_n = OPEN;
      OPEN:  if (cnt == '0) state_n = HOLD;
      HOLD:  if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs; latch_d moves only when leaving
  // IDLE and latch_en only on SETUP->OPEN and OPEN->HOLD, so they never
  // change on the same edge.
  always_comb begin
    cnt_n      = cnt;
    ptr_n      = ptr;
    gnt_n      = gnt;
    done_n     = '0;
    latch_d_n  = latch_d;
    latch_en_n = latch_en;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          gnt_n     = arb_sel;
          latch_d_n = wdata[int'(arb_idx)*WIDTH +: WIDTH];
          ptr_n     = arb_idx + 2'd1;
        end
      end
      SETUP: begin
        latch_en_n = 1'b1;
        cnt_n      = CNT_W'(OPEN_CYCLES - 1);
      end
      OPEN: begin
        if (cnt == '0) begin
          latch_en_n = 1'b0;
          cnt_n      = CNT_W'(HOLD_CYCLES - 1);
          if (HOLD_CYCLES == 1) done_n = gnt;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          gnt_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) done_n = gnt;
        end
      end
      default: begin
        gnt_n      = '0;
        latch_en_n = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Self-checking bench for latch_write_scheduler: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_latch_write_scheduler;

  localparam int W      = 8;
  localparam int OPEN_C = 2;
  localparam int HOLD_C = 1;
  localparam int OCC    = 1 + OPEN_C + HOLD_C;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt, done;
  logic        busy, latch_en;
  logic [7:0]  latch_d;
  logic [17:0] obs;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: cycles elapsed since the grant edge (-1 when idle).
  int         m_phase = -1;
  int         m_owner = 0;
  int         m_ptr   = 0;
  logic [7:0] m_d     = 8'h00;

  latch_write_scheduler #(
    .WIDTH(W), .N_REQ(4), .OPEN_CYCLES(OPEN_C), .HOLD_CYCLES(HOLD_C)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .done(done), .busy(busy), .latch_d(latch_d), .latch_en(latch_en)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, done, busy, latch_en, latch_d};

  task automatic model_edge(input logic [3:0] r, input logic [31:0] w, input logic rs);
    if (rs) begin
      m_phase = -1;
      m_ptr   = 0;
      m_d     = 8'h00;
    end else if (m_phase < 0) begin
      if (r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (r[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            break;
          end
        end
        m_d     = w[m_owner*8 +: 8];
        m_ptr   = (m_owner + 1) % 4;
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == OCC) m_phase = -1;
    end
  endtask

  // Expected {gnt, done, busy, latch_en, latch_d} after the latest edge.
  function automatic logic [17:0] exp_vec();
    logic [3:0] g;
    g = (m_phase >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, (m_phase == OCC - 1) ? g : 4'b0000, m_phase >= 0,
            (m_phase >= 1 && m_phase <= OPEN_C), m_d};
  endfunction

  task automatic step();
    model_edge(req, wdata, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; wdata = 32'hDEADBEEF;
    step();
    step();
    n_total++;
    if (obs !== 18'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int en_cnt = 0;
    int done_at = -1;
    apply_reset();
    req = 4'b0010;
    wdata = 32'h1234_A5_77;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL single_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      if (latch_en) en_cnt++;
      if (done[1]) done_at = c;
      if (c == 1) begin
        n_total++;
        if ({gnt, latch_d} !== {4'b0010, 8'hA5})
          $display("FAIL single_grant: got %h expected %h", {gnt, latch_d}, {4'b0010, 8'hA5});
        else n_pass++;
      end
      req = req & ~exp_vec()[13:10];
    end
    n_total++;
    if (en_cnt !== OPEN_C) $display("FAIL single_en_len: got %0d expected %0d", en_cnt, OPEN_C);
    else n_pass++;
    n_total++;
    if (done_at !== OCC) $display("FAIL single_done_time: got %0d expected %0d", done_at, OCC);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int         order[$];
    int         done_t[$];
    logic [3:0] prev_gnt = 4'b0000;
    logic [3:0] rearm = 4'b0000;
    int         exp_order[5] = '{0, 1, 2, 3, 0};
    int         c = 0;
    apply_reset();
    req = 4'b1111;
    wdata = $urandom;
    while (done_t.size() < 5 && c < 40) begin
      step();
      c++;
      n_total++;
      if (obs !== exp_vec()) $display("FAIL rr_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      if (prev_gnt == 4'b0000 && gnt != 4'b0000) order.push_back($clog2(int'(gnt)));
      if (done != 4'b0000) done_t.push_back(c);
      prev_gnt = gnt;
      req = req | rearm;
      rearm = exp_vec()[13:10];
      req = req & ~rearm;
      if (order.size() >= 5) rearm = 4'b0000;
    end
    n_total++;
    if (order.size() !== 5 || done_t.size() !== 5)
      $display("FAIL rr_timeout: got %0d grants expected 5", order.size());
    else n_pass++;
    for (int i = 0; i < order.size() && i < 5; i++) begin
      n_total++;
      if (order[i] !== exp_order[i])
        $display("FAIL rr_order%0d: got %0d expected %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    for (int i = 1; i < done_t.size(); i++) begin
      n_total++;
      if (done_t[i] - done_t[i-1] !== OCC + 1)
        $display("FAIL rr_spacing%0d: got %0d expected %0d", i, done_t[i] - done_t[i-1], OCC + 1);
      else n_pass++;
    end
    req = 4'b0000;
  endtask

  task automatic test_data_capture();
    apply_reset();
    req = 4'b0100;
    wdata = 32'h00_3C_00_00;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL capture_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      if (c <= OCC) begin
        n_total++;
        if (latch_d !== 8'h3C) $display("FAIL capture_d_c%0d: got %h expected 3c", c, latch_d);
        else n_pass++;
      end
      if (c == 2) wdata[23:16] = 8'hFF;
      req = req & ~exp_vec()[13:10];
    end
  endtask

  task automatic test_req_drop();
    int en_cnt = 0;
    int done_cnt = 0;
    apply_reset();
    req = 4'b1000;
    wdata = 32'h5A_00_00_00;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL drop_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      if (latch_en) en_cnt++;
      if (done[3]) done_cnt++;
      if (c == 2) req = 4'b0000;
    end
    n_total++;
    if ({en_cnt, done_cnt} !== {OPEN_C, 1})
      $display("FAIL drop_summary: got en=%0d done=%0d expected en=%0d done=1", en_cnt, done_cnt, OPEN_C);
    else n_pass++;
  endtask

  task automatic test_extra_req();
    int         grants = 0;
    int         extra = 0;
    logic [3:0] prev_gnt = 4'b0000;
    apply_reset();
    req = 4'b0011;
    wdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL extra_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      if (prev_gnt == 4'b0000 && gnt != 4'b0000) begin
        grants++;
        if (grants == 2) begin
          n_total++;
          if (gnt !== 4'b0010) $display("FAIL extra_second_grant: got %b expected 0010", gnt);
          else n_pass++;
        end
      end
      prev_gnt = gnt;
      if (extra == 1) begin
        req[0] = 1'b0;
        extra = 2;
      end
      if (exp_vec()[10] && extra == 0) extra = 1;
      req[1] = req[1] & ~exp_vec()[11];
    end
    n_total++;
    if (grants !== 2) $display("FAIL extra_grants: got %0d expected 2", grants);
    else n_pass++;
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0100;
    wdata = $urandom;
    step();
    step();
    n_total++;
    if (obs !== exp_vec() || latch_en !== 1'b1)
      $display("FAIL midrst_open: got %h expected %h", obs, exp_vec());
    else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if ({latch_en, gnt, busy, done} !== 10'b0)
      $display("FAIL midrst_abort: got %b expected 0", {latch_en, gnt, busy, done});
    else n_pass++;
    step();
    n_total++;
    if (obs !== exp_vec()) $display("FAIL midrst_hold: got %h expected %h", obs, exp_vec());
    else n_pass++;
    rst = 1'b0;
    req = 4'b1001;
    step();
    n_total++;
    if (gnt !== 4'b0001) $display("FAIL midrst_next_grant: got %b expected 0001", gnt);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      req = req & ~exp_vec()[13:10];
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL midrst_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      step();
      n_total++;
      if (obs !== exp_vec()) $display("FAIL random_c%0d: got %h expected %h", c, obs, exp_vec());
      else n_pass++;
      req = req & ~exp_vec()[13:10];
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          wdata[i*8 +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          wdata[i*8 +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    wdata = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_data_capture();
    test_req_drop();
    test_extra_req();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
